serial_addsub: RTL

Bit-serial adder/subtractor that turns our combinational full-adder and full-subtractor cells into a multi-cycle datapath unit. It accepts two parallel WIDTH-bit operands through a valid/ready handshake and processes them LSB-first, one bit per clock, through a single add/sub cell. It returns the parallel result with carry/borrow through a second valid/ready handshake. It is the sequential consumer end of the arithmetic primitives: a handshaked requester drives it, and a downstream unit receives its response.

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/serial_addsub_cell.sv | 19 +
 rtl/serial_addsub.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared op encoding and FSM state type for the bit-serial adder/subtractor.
package serial_addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_addsub_cell.sv
// Combinational 1-bit full adder / full subtractor, selected by op.
import serial_addsub_pkg::*;

module addsub_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic op,
   output logic s,
   output logic c_out
);

   always_comb begin
      s = a ^ b ^ c;
      if (op == OP_SUB) c_out = (~a & b) | (~(a ^ b) & c);
      else              c_out = (a & b) | (c & (a ^ b));
   end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/sub unit: LSB-first through one addsub_cell, valid/ready on both sides.
// Optional signed-overflow output is enabled with `define SERIAL_ADDSUB_OVF_EN.
import serial_addsub_pkg::*;

module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_sh, b_sh, res, res_nxt;
   logic               op_q, c_q;
   logic               s, c_out, last;

   assign last = (cnt == CNT_W'(WIDTH - 1));

   addsub_cell u_cell (
      .a     (a_sh[0]),
      .b     (b_sh[0]),
      .c     (c_q),
      .op    (op_q),
      .s     (s),
      .c_out (c_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // New result bit enters at the MSB so the word lands aligned after WIDTH shifts.
   always_comb begin
      res_nxt             = res >> 1;
      res_nxt[WIDTH-1]    = s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh <= '0;
         b_sh <= '0;
         res  <= '0;
         op_q <= 1'b0;
         c_q  <= 1'b0;
         cnt  <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_sh <= a;
               b_sh <= b;
               op_q <= op;
               c_q  <= cin;
               cnt  <= '0;
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               res  <= res_nxt;
               c_q  <= c_out;
               cnt  <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   logic ovf_q;

   // On the last bit a_sh[0]/b_sh[0] are the operand MSBs and s is the result MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else if (state == RUN && last) begin
         if (op_q == OP_SUB) ovf_q <= (a_sh[0] != b_sh[0]) && (s != a_sh[0]);
         else                ovf_q <= (a_sh[0] == b_sh[0]) && (s != a_sh[0]);
      end
   end

   assign ovf = ovf_q;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign result    = res;
   assign cout      = c_q;

endmodule
